// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator family.
// The output-width helper is common to the combinational operand trees.
package csa_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    HOLD    = 2'd2
  } csa_state_e;

  // Width that holds the sum of `opers` unsigned operands of `width` bits.
  function automatic int csa_out_w(input int width, input int opers);
    return width + $clog2(opers);
  endfunction

endpackage

// File: rtl/csa_compress32.sv
// One row of 3:2 carry-save compressors: three N-bit vectors in,
// redundant sum/carry pair out (carry pre-shifted, truncated to N bits).
module csa_compress32 #(
  parameter int N = 7
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  output logic [N-1:0] sum_o,
  output logic [N-1:0] carry_o
);

  logic [N-1:0] maj;

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign carry_o = maj << 1;

endmodule

// File: rtl/csa_stream_accum.sv
// Streaming multi-operand adder: operands accumulate in carry-save form,
// then a chunked carry-propagate pass resolves the frame total.
module csa_stream_accum
  import csa_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int MAX_OPERS = 6,
  parameter  int CHUNK     = 2,
  localparam int OUT_W     = csa_out_w(WIDTH, MAX_OPERS),
  localparam int CNT_W     = $clog2(MAX_OPERS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_trunc
);

  localparam int L     = (OUT_W + CHUNK - 1) / CHUNK;
  localparam int PAD_W = L * CHUNK;
  localparam int IDX_W = (L > 1) ? $clog2(L) : 1;

  csa_state_e           state_q, state_d;
  logic [OUT_W-1:0]     s_q, s_d;
  logic [OUT_W-1:0]     c_q, c_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 trunc_q, trunc_d;
  logic                 carry_q, carry_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [PAD_W-CHUNK-1:0] res_q, res_d;
  logic [OUT_W-1:0]     out_sum_q, out_sum_d;
  logic [CNT_W-1:0]     out_count_q, out_count_d;
  logic                 out_trunc_q, out_trunc_d;

  logic                 beat;
  logic                 close;
  logic [OUT_W-1:0]     x_ext;
  logic [OUT_W-1:0]     cmp_sum;
  logic [OUT_W-1:0]     cmp_carry;
  logic [CNT_W-1:0]     cnt_inc;
  logic [CHUNK:0]       chunk_sum;
  logic [PAD_W-1:0]     res_full;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_trunc = out_trunc_q;

  assign beat    = in_valid & in_ready;
  assign x_ext   = OUT_W'(in_data);
  assign cnt_inc = cnt_q + 1'b1;
  assign close   = in_last | (cnt_inc == CNT_W'(MAX_OPERS));

  csa_compress32 #(
    .N (OUT_W)
  ) u_compress (
    .a_i     (s_q),
    .b_i     (c_q),
    .c_i     (x_ext),
    .sum_o   (cmp_sum),
    .carry_o (cmp_carry)
  );

  // S and C shift right each RESOLVE cycle so the active chunk is always
  // at bit 0; resolved chunks enter res from the top, LSB chunk first.
  assign chunk_sum = {1'b0, s_q[CHUNK-1:0]} + {1'b0, c_q[CHUNK-1:0]}
                   + (CHUNK+1)'(carry_q);
  assign res_full  = {chunk_sum[CHUNK-1:0], res_q};

  // NOTE: every next-state signal takes its current value first, so no
  // path through the case leaves a variable unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    trunc_d     = trunc_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    res_d       = res_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_trunc_d = out_trunc_q;

    case (state_q)
      ACCUM: begin
        if (beat) begin
          s_d   = cmp_sum;
          c_d   = cmp_carry;
          cnt_d = cnt_inc;
          if (close) begin
            trunc_d = ~in_last;
            carry_d = 1'b0;
            idx_d   = '0;
            state_d = RESOLVE;
          end
        end
      end

      RESOLVE: begin
        s_d     = s_q >> CHUNK;
        c_d     = c_q >> CHUNK;
        carry_d = chunk_sum[CHUNK];
        res_d   = res_full[PAD_W-1:CHUNK];
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(L - 1)) begin
          // Final carry-out is dropped: the true total always fits OUT_W.
          out_sum_d   = res_full[OUT_W-1:0];
          out_count_d = cnt_q;
          out_trunc_d = trunc_q;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (out_ready) begin
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          trunc_d = 1'b0;
          carry_d = 1'b0;
          idx_d   = '0;
          res_d   = '0;
          state_d = ACCUM;
        end
      end

      default: state_d = ACCUM;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      trunc_q     <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      res_q       <= '0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      trunc_q     <= trunc_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      res_q       <= res_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_trunc_q <= out_trunc_d;
    end
  end

endmodule

// File: tb/tb_csa_stream_accum.sv
// Scenario bench for csa_stream_accum: expected frame results are queued
// as operands are driven and compared when the DUT hands each result over.
module tb_csa_stream_accum;

  localparam int WIDTH     = 4;
  localparam int MAX_OPERS = 6;
  localparam int OUT_W     = 7;
  localparam int CNT_W     = 3;

  typedef struct packed {
    logic [OUT_W-1:0] sum;
    logic [CNT_W-1:0] count;
    logic             trunc;
  } res_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_trunc;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   acc_sum = 0;
  int   acc_cnt = 0;
  res_t exp_q[$];

  csa_stream_accum #(
    .WIDTH     (WIDTH),
    .MAX_OPERS (MAX_OPERS),
    .CHUNK     (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_trunc (out_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_ready: in_ready=%0b required 1 within 100 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    acc_sum += int'(d);
    acc_cnt++;
    if (last || acc_cnt == MAX_OPERS) begin
      exp_q.push_back('{sum: OUT_W'(acc_sum), count: CNT_W'(acc_cnt), trunc: !last});
      acc_sum = 0;
      acc_cnt = 0;
    end
  endtask

  task automatic get_result(input int ready_pct, output res_t obs, output bit ok);
    ok  = 1'b0;
    obs = '0;
    for (int i = 0; i < 200 && !ok; i++) begin
      out_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (out_valid && out_ready) begin
        obs = '{sum: out_sum, count: out_count, trunc: out_trunc};
        ok  = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #2;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    n_tests++;
    if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum: got %0d required 0", out_sum); end
    n_tests++;
    if (out_count !== '0) begin n_fail++; $display("FAIL reset_out_count: got %0d required 0", out_count); end
    n_tests++;
    if (out_trunc !== 1'b0) begin n_fail++; $display("FAIL reset_out_trunc: got %0b required 0", out_trunc); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_max_frame();
    res_t exp, obs;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(4'd15, i == 5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== (k == 5)) begin
        n_fail++;
        $display("FAIL max_latency: cycle %0d out_valid=%0b required %0b", k, out_valid, k == 5);
      end
    end
    obs = '{sum: out_sum, count: out_count, trunc: out_trunc};
    exp = exp_q.pop_front();
    n_tests++;
    if (obs !== exp || exp.sum !== 7'd90) begin
      n_fail++;
      $display("FAIL max_result: got sum=%0d cnt=%0d tr=%0b required sum=90 cnt=6 tr=0 (model %0d/%0d/%0b)",
               obs.sum, obs.count, obs.trunc, exp.sum, exp.count, exp.trunc);
    end
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL max_release: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_single();
    res_t exp, obs;
    out_ready = 1'b1;
    send(4'd9, 1'b1);
    obs = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL single_busy: cycle %0d in_ready=%0b required 0", k, in_ready);
      end
      if (k == 5) obs = '{sum: out_sum, count: out_count, trunc: out_trunc};
    end
    exp = exp_q.pop_front();
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL single_result: got sum=%0d cnt=%0d tr=%0b required sum=%0d cnt=%0d tr=%0b",
               obs.sum, obs.count, obs.trunc, exp.sum, exp.count, exp.trunc);
    end
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_release: in_ready=%0b required 1", in_ready); end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    res_t exp, obs, obs2;
    bit   ok;
    out_ready = 1'b0;
    send(4'd2, 1'b0); idle(2);
    send(4'd0, 1'b0); idle(1);
    send(4'd7, 1'b0); idle(3);
    send(4'd3, 1'b1);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    n_tests++;
    if (!out_valid) begin n_fail++; $display("FAIL bp_timeout: out_valid=0 required 1"); end
    obs = '{sum: out_sum, count: out_count, trunc: out_trunc};
    exp = exp_q.pop_front();
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL bp_result: got sum=%0d cnt=%0d tr=%0b required sum=%0d cnt=%0d tr=%0b",
               obs.sum, obs.count, obs.trunc, exp.sum, exp.count, exp.trunc);
    end
    in_valid = 1'b1;
    in_data  = 4'd5;
    in_last  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== exp.sum || out_count !== exp.count) begin
        n_fail++;
        $display("FAIL bp_hold: valid=%0b ready=%0b sum=%0d cnt=%0d required 1/0/%0d/%0d",
                 out_valid, in_ready, out_sum, out_count, exp.sum, exp.count);
      end
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || out_sum !== exp.sum) begin
      n_fail++;
      $display("FAIL bp_last_hold: valid=%0b sum=%0d required 1/%0d", out_valid, out_sum, exp.sum);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    send(4'd1, 1'b1);
    get_result(100, obs2, ok);
    exp = exp_q.pop_front();
    n_tests++;
    if (!ok || obs2 !== exp) begin
      n_fail++;
      $display("FAIL bp_ignored: ok=%0b got sum=%0d cnt=%0d required sum=%0d cnt=%0d",
               ok, obs2.sum, obs2.count, exp.sum, exp.count);
    end
  endtask

  task automatic test_truncation();
    res_t exp, obs;
    bit   ok;
    for (int i = 1; i <= 6; i++) send(WIDTH'(i), 1'b0);
    get_result(100, obs, ok);
    exp = exp_q.pop_front();
    n_tests++;
    if (!ok || obs !== exp || exp.trunc !== 1'b1) begin
      n_fail++;
      $display("FAIL trunc_first: ok=%0b got sum=%0d cnt=%0d tr=%0b required sum=21 cnt=6 tr=1",
               ok, obs.sum, obs.count, obs.trunc);
    end
    send(4'd4, 1'b1);
    get_result(100, obs, ok);
    exp = exp_q.pop_front();
    n_tests++;
    if (!ok || obs !== exp) begin
      n_fail++;
      $display("FAIL trunc_second: ok=%0b got sum=%0d cnt=%0d tr=%0b required sum=%0d cnt=%0d tr=%0b",
               ok, obs.sum, obs.count, obs.trunc, exp.sum, exp.count, exp.trunc);
    end
  endtask

  task automatic test_reset_mid_resolve();
    res_t exp, obs;
    bit   ok;
    send(4'd11, 1'b0);
    send(4'd13, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: out_valid=%0b in_ready=%0b out_sum=%0d required 0/1/0",
               out_valid, in_ready, out_sum);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(4'd3, 1'b0);
    send(4'd5, 1'b1);
    get_result(100, obs, ok);
    exp = exp_q.pop_front();
    n_tests++;
    if (!ok || obs !== exp) begin
      n_fail++;
      $display("FAIL rst_next_frame: ok=%0b got sum=%0d cnt=%0d required sum=%0d cnt=%0d",
               ok, obs.sum, obs.count, exp.sum, exp.count);
    end
  endtask

  task automatic test_random();
    res_t exp, obs;
    bit   ok;
    int   len;
    logic last;
    for (int f = 0; f < 1000; f++) begin
      len = $urandom_range(1, MAX_OPERS);
      for (int j = 0; j < len; j++) begin
        last = (j == len - 1) && ((len < MAX_OPERS) || ($urandom_range(1) == 1));
        if ($urandom_range(3) == 0) idle(1);
        send(WIDTH'($urandom_range(15)), last);
      end
      get_result(50, obs, ok);
      exp = exp_q.pop_front();
      n_tests++;
      if (!ok || obs !== exp) begin
        n_fail++;
        $display("FAIL random_frame %0d: ok=%0b got sum=%0d cnt=%0d tr=%0b required sum=%0d cnt=%0d tr=%0b",
                 f, ok, obs.sum, obs.count, obs.trunc, exp.sum, exp.count, exp.trunc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_max_frame();
    test_single();
    test_backpressure();
    test_truncation();
    test_reset_mid_resolve();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
